key_input_port: RTL and testbench
=================================

// Module: key_input_port
// PURPOSE
//   Memory-mapped input peripheral on the CPU data bus (same re/we/addr/dataIn bus as the seg display).
//   Samples active-low push-buttons, synchronises and debounces each key, exposes debounced level
//   plus sticky press/release flags for CPU polling; optional level interrupt on press.
// PARAMETERS
//   CLK         50   system clock in MHz
//   DEBOUNCE_MS 20   input must be stable this long before accepted; DB_CNT = CLK*1000*DEBOUNCE_MS cycles
//   N_KEYS      4    number of keys, 1..8
// PORTS
//   clk      in   1       system clock, all logic on posedge
//   res      in   1       asynchronous, active-high reset
//   re       in   1       bus read enable
//   we       in   1       bus write enable
//   addr     in   32      byte address, full 32-bit compare
//   dataIn   in   32      write data
//   keys_n   in   N_KEYS  raw button pins, active-low, asynchronous to clk
//   dataOut  out  32      read data, combinational
//   irq      out  1       interrupt request, active-high level
// BEHAVIOUR
//   Register map (unlisted addresses: read 0, writes ignored):
//     0x0000_0030 KEY_STATE   RO   [N_KEYS-1:0] debounced level, 1 = pressed
//     0x0000_0034 KEY_PRESS   W1C  sticky flag per key, set on debounced 0->1
//     0x0000_0038 KEY_RELEASE W1C  sticky flag per key, set on debounced 1->0
//     0x0000_003c KEY_MASK    RW   per-key irq enable (KEY_IRQ_EN only)
//   Reset: sync flops 0, stable 0, all debounce counters 0, PRESS/RELEASE 0, MASK 0, irq 0.
//   Sync: ~keys_n through 2-flop synchroniser per key -> sync[i]; 2-cycle pin-to-sync latency.
//   Debounce per key, 32-bit counter cnt[i]:
//     sync==stable           -> cnt <= 0 (any bounce restarts the window)
//     sync!=stable, cnt<DB_CNT-1 -> cnt <= cnt+1
//     sync!=stable, cnt==DB_CNT-1 -> stable <= sync, cnt <= 0, set PRESS or RELEASE bit
//   Clean pin edge -> stable changes exactly DB_CNT+2 clocks later; pulse shorter than DB_CNT ignored.
//   Read: dataOut = selected register when re=1, else 32'd0; bits [31:N_KEYS] always 0. No read side effects.
//   Write (we=1): W1C registers clear bits where dataIn=1; MASK <= dataIn[N_KEYS-1:0].
//   Simultaneous set and W1C clear of same bit in same cycle -> set wins (flag stays 1).
//   re and we both high: write takes effect at edge, dataOut shows pre-write value that cycle.
//   Reset mid-debounce discards partial count; a held key re-qualifies after DB_CNT+2 clocks post-reset
//   and sets PRESS.
// CONFIGURATION
//   KEY_IRQ_EN defined: KEY_MASK register present; irq registered, irq <= |(KEY_PRESS & KEY_MASK),
//     so irq rises 1 clock after flag set, falls 1 clock after W1C/mask clears.
//   KEY_IRQ_EN undefined: no mask storage, 0x3c reads 0, writes ignored, irq tied 1'b0.
// TESTING (CLK=1, DEBOUNCE_MS=1 -> DB_CNT=1000, N_KEYS=4)
//   keys_n[0] 1->0 held -> KEY_STATE=0x1 and KEY_PRESS=0x1 exactly 1002 clocks after edge, not at 1001.
//   keys_n[1] low 600 clocks, high 10, low 600 -> KEY_STATE stays 0, no flags (bounce restarts count).
//   KEY_PRESS=0x1, write 0x1 to 0x34 -> reads 0x0; W1C in same cycle as new key-2 press -> reads 0x4.
//   key 3 press then release -> KEY_PRESS=0x8, KEY_RELEASE=0x8, KEY_STATE=0x0; re=0 -> dataOut=0.
//   KEY_IRQ_EN: MASK=0x2, press key 0 -> irq 0; press key 1 -> irq=1; W1C 0x2 to 0x34 -> irq=0 next clk.
//   res pulsed at cycle 500 of debounce with key held -> all regs 0, PRESS set 1002 clocks after res low.

Source files
------------

// File: rtl/key_input_port.sv
// key_input_port: memory-mapped push-button input peripheral.
// Each active-low key is synchronised, debounced and exposed to the CPU as a
// debounced level plus sticky press/release flags (write-one-to-clear).
// Optional feature macro: KEY_IRQ_EN adds the KEY_MASK register and a
// registered level interrupt on masked press flags. Without it, irq is 0.
//
// Register map (byte addresses, full 32-bit compare):
//   0x30 KEY_STATE   RO   debounced level, 1 = pressed
//   0x34 KEY_PRESS   W1C  sticky, set on debounced 0->1
//   0x38 KEY_RELEASE W1C  sticky, set on debounced 1->0
//   0x3c KEY_MASK    RW   per-key irq enable (KEY_IRQ_EN builds only)
module key_input_port #(
  parameter int CLK         = 50,
  parameter int DEBOUNCE_MS = 20,
  parameter int N_KEYS      = 4
) (
  input  logic              clk,
  input  logic              res,
  input  logic              re,
  input  logic              we,
  input  logic [31:0]       addr,
  input  logic [31:0]       dataIn,
  input  logic [N_KEYS-1:0] keys_n,
  output logic [31:0]       dataOut,
  output logic              irq
);

  // Debounce window length in clock cycles; the counter commits on its last count.
  localparam int unsigned DB_CNT  = CLK * 1000 * DEBOUNCE_MS;
  localparam logic [31:0] DB_LAST = 32'(DB_CNT - 1);

  localparam logic [31:0] ADDR_STATE   = 32'h0000_0030;
  localparam logic [31:0] ADDR_PRESS   = 32'h0000_0034;
  localparam logic [31:0] ADDR_RELEASE = 32'h0000_0038;
  localparam logic [31:0] ADDR_MASK    = 32'h0000_003c;

  logic [N_KEYS-1:0] r_sync1;
  logic [N_KEYS-1:0] r_sync2;
  logic [N_KEYS-1:0] r_stable;
  logic [N_KEYS-1:0] r_press;
  logic [N_KEYS-1:0] r_release;
  logic [31:0]       r_cnt [N_KEYS];

  logic [N_KEYS-1:0] w_commit;
  logic [N_KEYS-1:0] w_rise;
  logic [N_KEYS-1:0] w_fall;
  logic              w_wr_press;
  logic              w_wr_release;
  logic [N_KEYS-1:0] w_clr_press;
  logic [N_KEYS-1:0] w_clr_release;
  logic [N_KEYS-1:0] w_rd_key;
  logic              w_unused_data;

`ifdef KEY_IRQ_EN
  logic [N_KEYS-1:0] r_mask;
  logic              r_irq;
  logic              w_wr_mask;
`endif

  // Only the low N_KEYS bits of write data carry meaning.
  assign w_unused_data = ^dataIn[31:N_KEYS];

  // Two-flop synchroniser; pins are inverted here so 1 means pressed from now on.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= ~keys_n;
      r_sync2 <= r_sync1;
    end
  end

  // Keys whose synchronised level has disagreed with the accepted level for the whole window.
  always_comb begin
    w_commit = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_commit[i] = (r_sync2[i] != r_stable[i]) && (r_cnt[i] == DB_LAST);
    end
  end

  assign w_rise = w_commit & r_sync2;
  assign w_fall = w_commit & ~r_sync2;

  // Per-key debounce: any cycle matching the accepted level restarts the window.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_stable <= '0;
      for (int i = 0; i < N_KEYS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        if (r_sync2[i] == r_stable[i]) begin
          r_cnt[i] <= '0;
        end else if (r_cnt[i] == DB_LAST) begin
          r_stable[i] <= r_sync2[i];
          r_cnt[i]    <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + 32'd1;
        end
      end
    end
  end

  assign w_wr_press    = we && (addr == ADDR_PRESS);
  assign w_wr_release  = we && (addr == ADDR_RELEASE);
  assign w_clr_press   = w_wr_press   ? dataIn[N_KEYS-1:0] : '0;
  assign w_clr_release = w_wr_release ? dataIn[N_KEYS-1:0] : '0;

  // Sticky edge flags; a new edge in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_press   <= '0;
      r_release <= '0;
    end else begin
      r_press   <= (r_press   & ~w_clr_press)   | w_rise;
      r_release <= (r_release & ~w_clr_release) | w_fall;
    end
  end

`ifdef KEY_IRQ_EN
  assign w_wr_mask = we && (addr == ADDR_MASK);

  // Interrupt enable mask, plain read/write.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_mask <= '0;
    end else if (w_wr_mask) begin
      r_mask <= dataIn[N_KEYS-1:0];
    end
  end

  // Registered level interrupt: follows masked press flags one clock later.
  always_ff @(posedge clk or posedge res) begin
    if (res) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= |(r_press & r_mask);
    end
  end

  assign irq = r_irq;
`else
  assign irq = 1'b0;
`endif

  // Read mux; reads have no side effects and show pre-write values.
  always_comb begin
    w_rd_key = '0;
    case (addr)
      ADDR_STATE:   w_rd_key = r_stable;
      ADDR_PRESS:   w_rd_key = r_press;
      ADDR_RELEASE: w_rd_key = r_release;
`ifdef KEY_IRQ_EN
      ADDR_MASK:    w_rd_key = r_mask;
`endif
      default:      w_rd_key = '0;
    endcase
  end

  assign dataOut = re ? 32'(w_rd_key) : 32'd0;

endmodule

// File: tb/tb_key_input_port.sv
// Bench for key_input_port with DB_CNT = 1000 and 4 keys.
module tb_key_input_port;

  localparam int DB_CNT = 1000;

  logic        clk    = 1'b0;
  logic        res    = 1'b1;
  logic        re     = 1'b0;
  logic        we     = 1'b0;
  logic [31:0] addr   = 32'd0;
  logic [31:0] dataIn = 32'd0;
  logic [3:0]  keys_n = 4'hF;
  logic [31:0] dataOut;
  logic        irq;

  int total = 0;
  int bad   = 0;

  key_input_port #(.CLK(1), .DEBOUNCE_MS(1), .N_KEYS(4)) dut (
    .clk(clk), .res(res), .re(re), .we(we), .addr(addr), .dataIn(dataIn),
    .keys_n(keys_n), .dataOut(dataOut), .irq(irq)
  );

  always #10 clk = ~clk;

  // Reference model: a key level is accepted once the pin, seen two clocks late,
  // has held a value different from the accepted one for DB_CNT consecutive clocks.
  int unsigned cyc = 0;
  int unsigned m_run_start [4] = '{0, 0, 0, 0};
  logic [3:0]  m_d1 = '0, m_d2 = '0, m_last = '0;
  logic [3:0]  m_stable = '0, m_press = '0, m_release = '0, m_mask = '0;
  logic        m_irq = 1'b0;

  always @(posedge clk or posedge res) begin : ref_model
    logic [3:0] rise, fall, clr_p, clr_r;
    if (res) begin
      m_d1 <= '0; m_d2 <= '0; m_last <= '0; m_stable <= '0;
      m_press <= '0; m_release <= '0; m_mask <= '0; m_irq <= 1'b0;
      for (int i = 0; i < 4; i++) m_run_start[i] <= cyc;
    end else begin
      rise = '0;
      fall = '0;
      for (int i = 0; i < 4; i++) begin
        if (m_d2[i] != m_last[i]) begin
          m_last[i]      <= m_d2[i];
          m_run_start[i] <= cyc;
        end else if (m_d2[i] != m_stable[i] && (cyc - m_run_start[i]) == DB_CNT - 1) begin
          if (m_d2[i]) rise[i] = 1'b1;
          else         fall[i] = 1'b1;
        end
      end
      clr_p = (we && addr == 32'h34) ? dataIn[3:0] : 4'h0;
      clr_r = (we && addr == 32'h38) ? dataIn[3:0] : 4'h0;
      m_stable  <= (m_stable | rise) & ~fall;
      m_press   <= (m_press & ~clr_p) | rise;
      m_release <= (m_release & ~clr_r) | fall;
`ifdef KEY_IRQ_EN
      if (we && addr == 32'h3c) m_mask <= dataIn[3:0];
      m_irq <= |(m_press & m_mask);
`endif
      m_d1 <= ~keys_n;
      m_d2 <= m_d1;
      cyc  <= cyc + 1;
    end
  end

  function automatic logic [31:0] model_read(input logic [31:0] a, input logic r_en);
    logic [31:0] v;
    v = 32'd0;
    if (r_en) begin
      case (a)
        32'h30:  v = {28'd0, m_stable};
        32'h34:  v = {28'd0, m_press};
        32'h38:  v = {28'd0, m_release};
        32'h3c:  v = {28'd0, m_mask};
        default: v = 32'd0;
      endcase
    end
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    re = 1'b1; addr = a;
    #1;
    d = dataOut;
    re = 1'b0; addr = 32'd0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    we = 1'b1; addr = a; dataIn = d;
    @(negedge clk);
    we = 1'b0; addr = 32'd0; dataIn = 32'd0;
  endtask

  task automatic settle();
    keys_n = 4'hF;
    tick(1100);
    wr(32'h34, 32'hF);
    wr(32'h38, 32'hF);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] regs [5];
    regs = '{32'h30, 32'h34, 32'h38, 32'h3c, 32'h134};
    res = 1'b1;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      rd(regs[k], d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL reset_read[%h]: got %h want 0", regs[k], d); end
    end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq: got %b want 0", irq); end
    res = 1'b0;
    tick(2);
    rd(32'h30, d);
    total++; if (d !== 32'd0) begin bad++; $display("FAIL post_reset_state: got %h want 0", d); end
  endtask

  task automatic test_clean_press();
    logic [31:0] d;
    keys_n[0] = 1'b0;
    tick(DB_CNT + 1);
    rd(32'h30, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL state_at_1001: got %h want 0", d); end
    rd(32'h34, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL press_at_1001: got %h want 0", d); end
    tick(1);
    rd(32'h30, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL state_at_1002: got %h want 1", d); end
    rd(32'h34, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL press_at_1002: got %h want 1", d); end
    rd(32'h38, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL release_after_press: got %h want 0", d); end
  endtask

  task automatic test_w1c();
    logic [31:0] d;
    wr(32'h34, 32'h1);
    rd(32'h34, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h want 0", d); end
    rd(32'h30, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL w1c_state_kept: got %h want 1", d); end
    keys_n[2] = 1'b0;
    tick(DB_CNT + 1);
    wr(32'h34, 32'h4);
    rd(32'h34, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL set_wins_over_clear: got %h want 4", d); end
    rd(32'h30, d);
    total++; if (d !== 32'h5) begin bad++; $display("FAIL w1c_state_two_keys: got %h want 5", d); end
    settle();
  endtask

  task automatic test_bounce();
    logic [31:0] d;
    keys_n[1] = 1'b0; tick(600);
    keys_n[1] = 1'b1; tick(10);
    keys_n[1] = 1'b0; tick(600);
    rd(32'h30, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL bounce_state: got %h want 0", d); end
    keys_n[1] = 1'b1;
    tick(1100);
    rd(32'h34, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL bounce_press: got %h want 0", d); end
    rd(32'h38, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL bounce_release: got %h want 0", d); end
  endtask

  task automatic test_press_release();
    logic [31:0] d;
    keys_n[3] = 1'b0;
    tick(DB_CNT + 2);
    keys_n[3] = 1'b1;
    tick(DB_CNT + 1);
    rd(32'h38, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL release_at_1001: got %h want 0", d); end
    tick(1);
    rd(32'h30, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL pr_state: got %h want 0", d); end
    rd(32'h34, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL pr_press: got %h want 8", d); end
    rd(32'h38, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL pr_release: got %h want 8", d); end
    addr = 32'h34; re = 1'b0;
    #1;
    total++; if (dataOut !== 32'h0) begin bad++; $display("FAIL re_low_read: got %h want 0", dataOut); end
    addr = 32'd0;
  endtask

  task automatic test_rw_same_cycle();
    logic [31:0] d;
    @(negedge clk);
    re = 1'b1; we = 1'b1; addr = 32'h38; dataIn = 32'h8;
    #1;
    total++; if (dataOut !== 32'h8) begin bad++; $display("FAIL rw_pre_write_value: got %h want 8", dataOut); end
    @(negedge clk);
    re = 1'b0; we = 1'b0; addr = 32'd0; dataIn = 32'd0;
    rd(32'h38, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL rw_post_write: got %h want 0", d); end
    rd(32'h34, d);
    total++; if (d !== 32'h8) begin bad++; $display("FAIL rw_other_flag: got %h want 8", d); end
    settle();
  endtask

  task automatic test_irq();
    logic [31:0] d;
`ifdef KEY_IRQ_EN
    wr(32'h3c, 32'hFFFF_FFF2);
    rd(32'h3c, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL mask_readback: got %h want 2", d); end
    keys_n[0] = 1'b0;
    tick(DB_CNT + 3);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_unmasked_key: got %b want 0", irq); end
    keys_n[1] = 1'b0;
    tick(DB_CNT + 2);
    rd(32'h34, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL irq_press_flags: got %h want 3", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_same_clock_as_flag: got %b want 0", irq); end
    tick(1);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_rise: got %b want 1", irq); end
    wr(32'h34, 32'h2);
    total++; if (irq !== 1'b1) begin bad++; $display("FAIL irq_at_clear_edge: got %b want 1", irq); end
    tick(1);
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL irq_fall: got %b want 0", irq); end
`else
    keys_n[1] = 1'b0;
    tick(DB_CNT + 4);
    rd(32'h34, d);
    total++; if (d !== 32'h2) begin bad++; $display("FAIL noirq_press: got %h want 2", d); end
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL noirq_irq: got %b want 0", irq); end
    wr(32'h3c, 32'hF);
    rd(32'h3c, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL noirq_mask_read: got %h want 0", d); end
`endif
    settle();
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic [31:0] regs [4];
    regs = '{32'h30, 32'h34, 32'h38, 32'h3c};
    keys_n[2] = 1'b0;
    tick(500);
    res = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rd(regs[k], d);
      total++; if (d !== 32'd0) begin bad++; $display("FAIL midreset_read[%h]: got %h want 0", regs[k], d); end
    end
    res = 1'b0;
    tick(DB_CNT + 1);
    rd(32'h30, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL midreset_state_1001: got %h want 0", d); end
    tick(1);
    rd(32'h30, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL midreset_state_1002: got %h want 4", d); end
    rd(32'h34, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL midreset_press_1002: got %h want 4", d); end
    settle();
  endtask

  task automatic test_random();
    int hold [4];
    logic [31:0] addrs [6];
    logic [31:0] ra, exp_d;
    logic r_en;
    addrs = '{32'h30, 32'h34, 32'h38, 32'h3c, 32'h40, 32'h134};
    for (int i = 0; i < 4; i++) hold[i] = $urandom_range(1, 1500);
    for (int c = 0; c < 25000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          keys_n[i] = ~keys_n[i];
          case ($urandom_range(0, 2))
            0:       hold[i] = $urandom_range(1, 900);
            1:       hold[i] = $urandom_range(995, 1005);
            default: hold[i] = $urandom_range(1006, 3000);
          endcase
        end else begin
          hold[i]--;
        end
      end
      ra = addrs[$urandom_range(0, 5)];
      r_en = ($urandom_range(0, 7) != 0);
      addr = ra; re = r_en; we = 1'b0; dataIn = 32'd0;
      if ($urandom_range(0, 31) == 0) begin
        we = 1'b1;
        dataIn = $urandom();
      end
      #1;
      exp_d = model_read(ra, r_en);
      total++; if (dataOut !== exp_d) begin bad++; $display("FAIL random_read[%h] c=%0d: got %h want %h", ra, c, dataOut, exp_d); end
      total++; if (irq !== m_irq) begin bad++; $display("FAIL random_irq c=%0d: got %b want %b", c, irq, m_irq); end
      @(negedge clk);
    end
    re = 1'b0; we = 1'b0; addr = 32'd0; dataIn = 32'd0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_w1c();
    test_bounce();
    test_press_release();
    test_rw_same_cycle();
    test_irq();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(20 * 80000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "cycle budget exceeded");
  end

endmodule
